call_ret_ctrl: RTL

Subroutine call/return sequencer that sits directly upstream of the data stack and drives its push/pop interface. The decoder issues single-cycle CALL or RET requests. The block splits the PC_WIDTH-bit return address into DATA_SIZE-bit stack words on CALL, reassembles them on RET, and hands a load value to the program counter. It also keeps a frame-depth count so that over- and underflow are detected before the stack is touched.

---
 rtl/call_ret_pkg.sv | 25 ++
 rtl/call_ret_ctrl.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/call_ret_pkg.sv
// Shared types and sizing helpers for the call/return sequencer.
// Holds the sequencer state encoding and the frame-geometry functions.
// No logic of its own; imported by call_ret_ctrl.
package call_ret_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PUSH = 3'd1,
    POP  = 3'd2,
    WAIT = 3'd3,
    LOAD = 3'd4
  } state_t;

  // Stack words needed to hold one return address.
  function automatic int words_per_frame(input int pc_width, input int data_size);
    return pc_width / data_size;
  endfunction

  // Whole frames that fit in a stack of 2**stack_size-1 words.
  function automatic int max_frames(input int pc_width, input int data_size,
                                    input int stack_size);
    return ((2 ** stack_size) - 1) / words_per_frame(pc_width, data_size);
  endfunction

endpackage

// File: rtl/call_ret_ctrl.sv
// Purpose: splits return addresses into stack words on CALL, reassembles them on RET, loads the PC.
// Latency: CALL loads the PC N+1 cycles after the request, RET N+2 cycles; depth updates with the load.
// Backpressure: none on the stack side; decoder requests are ignored while BUSY is high.
// Optional over/underflow rejection with sticky FAULT is built when CALL_RET_FAULT_EN is defined.
module call_ret_ctrl #(
  parameter int DATA_SIZE  = 4,
  parameter int PC_WIDTH   = 8,
  parameter int STACK_SIZE = 5
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CALL_REQ,
  input  logic                  RET_REQ,
  input  logic [PC_WIDTH-1:0]   PC_IN,
  input  logic [PC_WIDTH-1:0]   TARGET,
  output logic                  BUSY,
  output logic                  PC_LOAD,
  output logic [PC_WIDTH-1:0]   PC_LOAD_VAL,
  output logic                  STK_W,
  output logic                  STK_R,
  output logic [DATA_SIZE-1:0]  STK_DATA_WR,
  input  logic [DATA_SIZE-1:0]  STK_DATA_RD,
  output logic [STACK_SIZE-1:0] DEPTH,
  output logic                  FAULT
);
  import call_ret_pkg::*;

  localparam int N          = words_per_frame(PC_WIDTH, DATA_SIZE);
  localparam int MAX_FRAMES = max_frames(PC_WIDTH, DATA_SIZE, STACK_SIZE);
  localparam int CNT_W      = $clog2(N + 1);

  localparam logic [STACK_SIZE-1:0] DEPTH_MAX = STACK_SIZE'(MAX_FRAMES);
  localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(N);
  localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [PC_WIDTH-1:0]  push_sr;   // return address, shifted down one word per push
  logic [PC_WIDTH-1:0]  pop_acc;   // popped words, most-significant first
  logic [PC_WIDTH-1:0]  tgt;
  logic [PC_WIDTH-1:0]  ret_addr;
  logic [PC_WIDTH-1:0]  pop_acc_next;

  assign ret_addr     = PC_IN + PC_WIDTH'(1);
  assign pop_acc_next = (pop_acc << DATA_SIZE) | PC_WIDTH'(STK_DATA_RD);

`ifndef CALL_RET_FAULT_EN
  assign FAULT = 1'b0;
`endif

  // Sequencer: one registered FSM driving every output.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      cnt         <= '0;
      push_sr     <= '0;
      pop_acc     <= '0;
      tgt         <= '0;
      BUSY        <= 1'b0;
      PC_LOAD     <= 1'b0;
      PC_LOAD_VAL <= '0;
      STK_W       <= 1'b0;
      STK_R       <= 1'b0;
      STK_DATA_WR <= '0;
      DEPTH       <= '0;
`ifdef CALL_RET_FAULT_EN
      FAULT       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (CALL_REQ) begin
`ifdef CALL_RET_FAULT_EN
            if (DEPTH == DEPTH_MAX) FAULT <= 1'b1;
            else
`endif
            begin
              state       <= PUSH;
              BUSY        <= 1'b1;
              STK_W       <= 1'b1;
              STK_DATA_WR <= ret_addr[DATA_SIZE-1:0];
              push_sr     <= ret_addr >> DATA_SIZE;
              tgt         <= TARGET;
              cnt         <= CNT_ONE;
            end
          end else if (RET_REQ) begin
`ifdef CALL_RET_FAULT_EN
            if (DEPTH == '0) FAULT <= 1'b1;
            else
`endif
            begin
              state   <= POP;
              BUSY    <= 1'b1;
              STK_R   <= 1'b1;
              pop_acc <= '0;
              cnt     <= CNT_ONE;
            end
          end
        end
        PUSH: begin
          if (cnt == CNT_LAST) begin
            state       <= LOAD;
            STK_W       <= 1'b0;
            PC_LOAD     <= 1'b1;
            PC_LOAD_VAL <= tgt;
            if (DEPTH != DEPTH_MAX) DEPTH <= DEPTH + STACK_SIZE'(1);
          end else begin
            STK_DATA_WR <= push_sr[DATA_SIZE-1:0];
            push_sr     <= push_sr >> DATA_SIZE;
            cnt         <= cnt + CNT_ONE;
          end
        end
        POP: begin
          // Pop data lags its strobe by one cycle, so the first strobe has nothing to capture.
          if (cnt != CNT_ONE) pop_acc <= pop_acc_next;
          if (cnt == CNT_LAST) begin
            state <= WAIT;
            STK_R <= 1'b0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        WAIT: begin
          state       <= LOAD;
          PC_LOAD     <= 1'b1;
          PC_LOAD_VAL <= pop_acc_next;
          if (DEPTH != '0) DEPTH <= DEPTH - STACK_SIZE'(1);
        end
        LOAD: begin
          state   <= IDLE;
          PC_LOAD <= 1'b0;
          BUSY    <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          BUSY    <= 1'b0;
          PC_LOAD <= 1'b0;
          STK_W   <= 1'b0;
          STK_R   <= 1'b0;
        end
      endcase
    end
  end

endmodule
